mig_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single DDR controller user (app_*) interface, running entirely in the ui_clk domain. Port 0 serves the CPU-side bridge traffic; port 1 serves a second master, such as a display or DMA engine. Each port presents one 128-bit command at a time. Grants are round-robin, the arbiter keeps exactly one transaction in flight on the app interface, and read data or write completion is returned to the owning port.

---
 rtl/mig_arbiter.sv | 148 ++++++++++++++
 tb/tb_mig_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_arbiter.sv
// Round-robin two-port arbiter in front of the DDR controller app interface.
// One transaction in flight; read data or write completion goes back to the owning port.
module mig_arbiter (
    input  logic         ui_clk,
    input  logic         myrst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_read,
    input  logic [27:0]  req0_addr,
    input  logic [127:0] req0_wdata,
    input  logic [15:0]  req0_wmask,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_read,
    input  logic [27:0]  req1_addr,
    input  logic [127:0] req1_wdata,
    input  logic [15:0]  req1_wmask,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [127:0] rsp0_rdata,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp1_rdata,
    output logic [27:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    output logic [127:0] app_wdf_data,
    output logic [15:0]  app_wdf_mask,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    input  logic         app_rdy,
    input  logic         app_wdf_rdy,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid,
    output logic [1:0]   arb_state
);

    // state    | meaning
    // S_IDLE   | no transaction; grant a waiting port
    // S_ISSUE  | command presented on app_*, waiting for controller accept
    // S_RDWAIT | read accepted, waiting for app_rd_data_valid
    // S_RSP    | response held on owner's rsp port until accepted
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RDWAIT = 2'd2,
        S_RSP    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           owner_q, owner_d;
    logic           cmd_read_q, cmd_read_d;
    logic [27:0]    cmd_addr_q, cmd_addr_d;
    logic [127:0]   cmd_wdata_q, cmd_wdata_d;
    logic [15:0]    cmd_wmask_q, cmd_wmask_d;
    logic [127:0]   rsp0_rdata_q, rsp0_rdata_d;
    logic [127:0]   rsp1_rdata_q, rsp1_rdata_d;
    logic           winner;

    always_ff @(posedge ui_clk or negedge myrst) begin
        if (!myrst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cmd_read_q   <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_wmask_q  <= '0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cmd_read_q   <= cmd_read_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_wmask_q  <= cmd_wmask_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cmd_read_d   = cmd_read_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_wmask_d  = cmd_wmask_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        // on a tie the port that did not win last time goes next
        winner       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

        case (state_q)
            S_IDLE: begin
                if (myrst && (req0_valid || req1_valid)) begin
                    req0_ready   = ~winner;
                    req1_ready   = winner;
                    cmd_read_d   = winner ? req1_read  : req0_read;
                    cmd_addr_d   = winner ? req1_addr  : req0_addr;
                    cmd_wdata_d  = winner ? req1_wdata : req0_wdata;
                    cmd_wmask_d  = winner ? req1_wmask : req0_wmask;
                    owner_d      = winner;
                    last_grant_d = winner;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (app_rdy && (cmd_read_q || app_wdf_rdy)) begin
                    state_d = cmd_read_q ? S_RDWAIT : S_RSP;
                end
            end
            S_RDWAIT: begin
                if (app_rd_data_valid) begin
                    if (owner_q) rsp1_rdata_d = app_rd_data;
                    else         rsp0_rdata_d = app_rd_data;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign app_en       = (state_q == S_ISSUE);
    assign app_wdf_wren = app_en & ~cmd_read_q;
    assign app_wdf_end  = app_en & ~cmd_read_q;
    assign app_addr     = cmd_addr_q;
    assign app_cmd      = {2'b00, cmd_read_q};
    assign app_wdf_data = cmd_wdata_q;
    assign app_wdf_mask = cmd_wmask_q;
    assign rsp0_valid   = (state_q == S_RSP) && !owner_q;
    assign rsp1_valid   = (state_q == S_RSP) && owner_q;
    assign rsp0_rdata   = rsp0_rdata_q;
    assign rsp1_rdata   = rsp1_rdata_q;
    assign arb_state    = state_q;

endmodule

// File: tb/tb_mig_arbiter.sv
// Randomized bench for mig_arbiter: transaction-level reference model tracks the one
// in-flight command and predicts every app/req/rsp output cycle by cycle.
module tb_mig_arbiter;

    logic         ui_clk = 1'b0;
    logic         myrst  = 1'b0;
    logic         req0_valid = 0, req0_read = 0, req1_valid = 0, req1_read = 0;
    logic [27:0]  req0_addr = 0, req1_addr = 0;
    logic [127:0] req0_wdata = 0, req1_wdata = 0;
    logic [15:0]  req0_wmask = 0, req1_wmask = 0;
    logic         req0_ready, req1_ready;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 0, rsp1_ready = 0;
    logic [127:0] rsp0_rdata, rsp1_rdata;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_wdf_wren, app_wdf_end;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_rdy = 0, app_wdf_rdy = 0, app_rd_data_valid = 0;
    logic [127:0] app_rd_data = 0;
    logic [1:0]   arb_state;

    always #5 ui_clk = ~ui_clk;

    mig_arbiter dut (
        .ui_clk(ui_clk), .myrst(myrst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_read(req0_read),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_read(req1_read),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .arb_state(arb_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: one transaction record plus per-port response data
    bit           m_busy, m_acc, m_back, m_owner, m_last, m_read;
    logic [27:0]  m_addr;
    logic [127:0] m_wdata;
    logic [15:0]  m_wmask;
    logic [127:0] m_rdata [2];
    int           grant_log [$];

    // requester side: one pending command per port
    bit           pend [2];
    bit           p_read [2];
    logic [27:0]  p_addr [2];
    logic [127:0] p_wdata [2];
    logic [15:0]  p_wmask [2];

    int unsigned  k_req [2];
    int unsigned  k_rdy, k_wdf, k_rsp, k_stray;
    int           k_mode;
    bit           k_hold_rd;
    int           rd_cnt;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit issuing();
        return m_busy && !m_acc;
    endfunction
    function automatic bit waiting();
        return m_busy && m_acc && m_read && !m_back;
    endfunction
    function automatic bit responding();
        return m_busy && m_acc && (!m_read || m_back);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_back = 0; m_owner = 0; m_last = 1; m_read = 0;
        m_addr = '0; m_wdata = '0; m_wmask = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        pend[0] = 0; pend[1] = 0;
        rd_cnt = 0;
    endtask

    task automatic step();
        bit       grant, w;
        logic [1:0] exp_state;
        @(posedge ui_clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(99) < k_req[p]) begin
                pend[p]    = 1;
                p_read[p]  = (k_mode == 2) ? 1'($urandom_range(1)) : (k_mode == 1);
                p_addr[p]  = 28'($urandom);
                p_wdata[p] = rnd128();
                p_wmask[p] = 16'($urandom);
            end
        end
        req0_valid = pend[0]; req0_read = p_read[0]; req0_addr = p_addr[0];
        req0_wdata = p_wdata[0]; req0_wmask = p_wmask[0];
        req1_valid = pend[1]; req1_read = p_read[1]; req1_addr = p_addr[1];
        req1_wdata = p_wdata[1]; req1_wmask = p_wmask[1];
        app_rdy     = $urandom_range(99) < k_rdy;
        app_wdf_rdy = $urandom_range(99) < k_wdf;
        rsp0_ready  = $urandom_range(99) < k_rsp;
        rsp1_ready  = $urandom_range(99) < k_rsp;
        app_rd_data = rnd128();
        if (waiting()) begin
            if (k_hold_rd) app_rd_data_valid = 0;
            else if (rd_cnt == 0) app_rd_data_valid = 1;
            else begin
                app_rd_data_valid = 0;
                rd_cnt--;
            end
        end else begin
            app_rd_data_valid = $urandom_range(99) < k_stray;
        end
        #1;
        w = (pend[0] && pend[1]) ? !m_last : pend[1];
        grant = !m_busy && (pend[0] || pend[1]);
        exp_state = !m_busy ? 2'd0 : issuing() ? 2'd1 : waiting() ? 2'd2 : 2'd3;
        chk("req0_ready", req0_ready, grant && !w);
        chk("req1_ready", req1_ready, grant && w);
        chk("app_en", app_en, issuing());
        chk("app_wdf_wren", app_wdf_wren, issuing() && !m_read);
        chk("app_wdf_end", app_wdf_end, issuing() && !m_read);
        chk("app_addr", app_addr, m_addr);
        chk("app_cmd", app_cmd, {2'b00, m_read});
        chk("app_wdf_data", app_wdf_data, m_wdata);
        chk("app_wdf_mask", app_wdf_mask, m_wmask);
        chk("rsp0_valid", rsp0_valid, responding() && !m_owner);
        chk("rsp1_valid", rsp1_valid, responding() && m_owner);
        chk("rsp0_rdata", rsp0_rdata, m_rdata[0]);
        chk("rsp1_rdata", rsp1_rdata, m_rdata[1]);
        chk("arb_state", arb_state, exp_state);
        if (grant) begin
            m_busy = 1; m_acc = 0; m_back = 0;
            m_owner = w; m_last = w;
            m_read = p_read[w]; m_addr = p_addr[w];
            m_wdata = p_wdata[w]; m_wmask = p_wmask[w];
            pend[w] = 0;
            grant_log.push_back(int'(w));
        end else if (issuing()) begin
            if (app_rdy && (m_read || app_wdf_rdy)) begin
                m_acc = 1;
                rd_cnt = $urandom_range(10);
            end
        end else if (waiting()) begin
            if (app_rd_data_valid) begin
                m_rdata[m_owner] = app_rd_data;
                m_back = 1;
            end
        end else if (responding()) begin
            if (m_owner ? rsp1_ready : rsp0_ready) m_busy = 0;
        end
    endtask

    task automatic run(input int cycles, input int unsigned r0, input int unsigned r1,
                       input int mode, input int unsigned rdy, input int unsigned wdf,
                       input int unsigned rsp, input int unsigned stray);
        k_req[0] = r0; k_req[1] = r1; k_mode = mode;
        k_rdy = rdy; k_wdf = wdf; k_rsp = rsp; k_stray = stray;
        repeat (cycles) step();
    endtask

    initial begin
        int budget;
        bit alt_ok;
        model_reset();
        k_hold_rd = 0;
        #1;
        chk("rst_state", arb_state, 2'd0);
        chk("rst_app_en", app_en, 1'b0);
        chk("rst_rdata0", rsp0_rdata, '0);
        repeat (2) @(posedge ui_clk);
        #1 myrst = 1'b1;

        run(40, 60, 0, 0, 100, 100, 100, 0);    // port 0 writes, no backpressure
        run(60, 0, 60, 1, 100, 100, 100, 0);    // port 1 reads
        grant_log.delete();
        run(120, 100, 100, 2, 100, 100, 100, 0); // both always requesting
        alt_ok = grant_log.size() >= 4;
        for (int i = 0; i < grant_log.size(); i++)
            if (grant_log[i] != (i % 2)) alt_ok = 0;
        chk("rr_alternate", alt_ok, 1'b1);
        run(400, 50, 50, 2, 60, 40, 50, 10);    // backpressure everywhere, strays
        run(150, 30, 80, 0, 100, 20, 30, 10);

        // reset while a read is outstanding
        k_hold_rd = 1;
        k_req[0] = 100; k_req[1] = 0; k_mode = 1;
        k_rdy = 100; k_wdf = 100; k_rsp = 100; k_stray = 0;
        budget = 200;
        while (!waiting() && budget > 0) begin
            step();
            budget--;
        end
        chk("reach_rdwait", waiting(), 1'b1);
        step();
        @(posedge ui_clk);
        #1;
        req0_valid = 1; req1_valid = 0; app_rdy = 0; app_wdf_rdy = 0;
        rsp0_ready = 0; rsp1_ready = 0; app_rd_data_valid = 0;
        myrst = 1'b0;
        #1;
        chk("rst_mid_state", arb_state, 2'd0);
        chk("rst_mid_app_en", app_en, 1'b0);
        chk("rst_mid_addr", app_addr, '0);
        chk("rst_mid_cmd", app_cmd, '0);
        chk("rst_mid_wdata", app_wdf_data, '0);
        chk("rst_mid_wmask", app_wdf_mask, '0);
        chk("rst_mid_ready0", req0_ready, 1'b0);
        chk("rst_mid_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("rst_mid_rdata0", rsp0_rdata, '0);
        chk("rst_mid_rdata1", rsp1_rdata, '0);
        #20;
        @(posedge ui_clk);
        #1;
        req0_valid = 0;
        model_reset();
        myrst = 1'b1;
        k_hold_rd = 0;
        run(6, 0, 0, 1, 100, 100, 100, 100);    // late read return arrives as a stray
        run(300, 40, 40, 2, 70, 60, 60, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
